// File: rtl/pma_region_table.sv
// pma_region_table
//   Runtime-programmable table of NrRules physical-memory-attribute regions.
//   Each entry holds {base, len, attr, lock}. Address lookups flow through a
//   two-stage, back-pressured pipeline and return hit, lowest matching index
//   and that entry's attributes (DefaultAttr on miss).
//
//   Optional feature macro: PMA_MULTIHIT_ERR_EN
//     defined   -> rsp_multihit_o flags lookups that matched more than one entry
//     undefined -> rsp_multihit_o is tied to 0 and no overlap detection is built
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               drop every in-flight lookup; blocks acceptance this cycle
//   cfg_we_i .. cfg_lock_i  entry write port (index, base, len, attr, lock)
//   cfg_err_o             one-cycle pulse after a write to a locked or nonexistent entry
//   req_valid_i/ready_o   lookup request handshake, req_addr_i = address
//   rsp_valid_o/ready_i   response handshake
//   rsp_hit_o, rsp_idx_o, rsp_attr_o, rsp_multihit_o  lookup result
module pma_region_table #(
  parameter int unsigned NrRules   = 16,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned NrAttr    = 3,
  parameter logic [NrAttr-1:0] DefaultAttr = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLen  = '0,
  parameter logic [NrRules-1:0][NrAttr-1:0]    RstAttr = '0,
  // A single-entry table still needs a 1-bit index port.
  localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [NrAttr-1:0]    cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic [NrAttr-1:0]    rsp_attr_o,
  output logic                 rsp_multihit_o
);

  // ---------------------------------------------------------------- table
  logic [NrRules-1:0][AddrWidth-1:0] baseQ;
  logic [NrRules-1:0][AddrWidth-1:0] lenQ;
  logic [NrRules-1:0][NrAttr-1:0]    attrQ;
  logic [NrRules-1:0]                lockQ;
  logic                              cfgErrQ;

  logic cfgIdxValid;
  logic cfgTargetLocked;
  logic cfgWrite;

  always_comb begin
    cfgIdxValid     = (32'(cfg_idx_i) < NrRules);
    cfgTargetLocked = 1'b0;
    for (int k = 0; k < int'(NrRules); k++) begin
      if (cfg_idx_i == IdxWidth'(k)) cfgTargetLocked = lockQ[k];
    end
    cfgWrite = cfg_we_i & cfgIdxValid & ~cfgTargetLocked;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baseQ   <= RstBase;
      lenQ    <= RstLen;
      attrQ   <= RstAttr;
      lockQ   <= '0;
      cfgErrQ <= 1'b0;
    end else begin
      cfgErrQ <= cfg_we_i & ~cfgWrite;
      for (int k = 0; k < int'(NrRules); k++) begin
        if (cfgWrite && (cfg_idx_i == IdxWidth'(k))) begin
          baseQ[k] <= cfg_base_i;
          lenQ[k]  <= cfg_len_i;
          attrQ[k] <= cfg_attr_i;
          // Entry was unlocked or the write would have been refused.
          lockQ[k] <= cfg_lock_i;
        end
      end
    end
  end

  assign cfg_err_o = cfgErrQ;

  // ------------------------------------------------------ per-rule match
  // The upper bound is formed one bit wider so a region ending exactly at
  // the top of the address space neither wraps nor loses its last byte.
  logic [NrRules-1:0] matchVec;
  logic [AddrWidth:0] limit;

  always_comb begin
    matchVec = '0;
    limit    = '0;
    for (int k = 0; k < int'(NrRules); k++) begin
      limit       = {1'b0, baseQ[k]} + {1'b0, lenQ[k]};
      matchVec[k] = (lenQ[k] != '0) && (req_addr_i >= baseQ[k]) &&
                    ({1'b0, req_addr_i} < limit);
    end
  end

  // -------------------------------------------------------- flow control
  logic s0Valid, s1Valid;
  logic s0Adv, s1Adv;

  assign s1Adv       = ~s1Valid | rsp_ready_i;
  assign s0Adv       = ~s0Valid | s1Adv;
  assign req_ready_o = s0Adv & ~flush_i;

  // ------------------------------------------------------------- stage 0
  // Attributes are captured with the match vector so a table write after
  // acceptance cannot change the answer of a lookup already in flight.
  logic [NrRules-1:0]             s0Match;
  logic [NrRules-1:0][NrAttr-1:0] s0Attr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0Valid <= 1'b0;
      s0Match <= '0;
      s0Attr  <= '0;
    end else if (flush_i) begin
      s0Valid <= 1'b0;
    end else if (s0Adv) begin
      s0Valid <= req_valid_i;
      if (req_valid_i) begin
        s0Match <= matchVec;
        s0Attr  <= attrQ;
      end
    end
  end

  // ---------------------------------------------------- priority encoder
  // Descending scan so the lowest matching index is the last assignment.
  logic                encHit;
  logic [IdxWidth-1:0] encIdx;
  logic [NrAttr-1:0]   encAttr;

  always_comb begin
    encHit  = 1'b0;
    encIdx  = '0;
    encAttr = DefaultAttr;
    for (int k = int'(NrRules) - 1; k >= 0; k--) begin
      if (s0Match[k]) begin
        encHit  = 1'b1;
        encIdx  = IdxWidth'(k);
        encAttr = s0Attr[k];
      end
    end
  end

  // ------------------------------------------------------------- stage 1
  logic                s1Hit;
  logic [IdxWidth-1:0] s1Idx;
  logic [NrAttr-1:0]   s1Attr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1Valid <= 1'b0;
      s1Hit   <= 1'b0;
      s1Idx   <= '0;
      s1Attr  <= DefaultAttr;
    end else if (flush_i) begin
      s1Valid <= 1'b0;
    end else if (s1Adv) begin
      s1Valid <= s0Valid;
      if (s0Valid) begin
        s1Hit  <= encHit;
        s1Idx  <= encIdx;
        s1Attr <= encAttr;
      end
    end
  end

  assign rsp_valid_o = s1Valid;
  assign rsp_hit_o   = s1Hit;
  assign rsp_idx_o   = s1Idx;
  assign rsp_attr_o  = s1Attr;

  // ------------------------------------------------ overlap detection
`ifdef PMA_MULTIHIT_ERR_EN
  logic s0Multi, s1Multi;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0Multi <= 1'b0;
    end else if (!flush_i && s0Adv && req_valid_i) begin
      // More than one bit set <=> clearing the lowest set bit leaves something.
      s0Multi <= |(matchVec & (matchVec - NrRules'(1)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1Multi <= 1'b0;
    end else if (!flush_i && s1Adv && s0Valid) begin
      s1Multi <= s0Multi;
    end
  end

  assign rsp_multihit_o = s1Multi;
`else
  assign rsp_multihit_o = 1'b0;
`endif

endmodule

// File: tb/tb_pma_region_table.sv
module tb_pma_region_table;

  localparam int NrRules   = 5;
  localparam int AddrWidth = 64;
  localparam int NrAttr    = 3;
  localparam int IdxW      = 3;
  localparam logic [NrAttr-1:0] DefAttr = 3'b101;
  localparam logic [NrRules-1:0][AddrWidth-1:0] RB =
    {64'h4000, 64'h0, 64'h0, 64'h0, 64'h0};
  localparam logic [NrRules-1:0][AddrWidth-1:0] RL =
    {64'h100, 64'h0, 64'h0, 64'h0, 64'h0};
  localparam logic [NrRules-1:0][NrAttr-1:0] RA =
    {3'b011, 3'b000, 3'b000, 3'b000, 3'b000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 flush, cfgWe, cfgLock, reqValid, rspReady;
  logic [IdxW-1:0]      cfgIdx;
  logic [AddrWidth-1:0] cfgBase, cfgLen, reqAddr;
  logic [NrAttr-1:0]    cfgAttr;
  logic                 cfgErr, reqReady, rspValid, rspHit, rspMulti;
  logic [IdxW-1:0]      rspIdx;
  logic [NrAttr-1:0]    rspAttr;

  pma_region_table #(
    .NrRules(NrRules), .AddrWidth(AddrWidth), .NrAttr(NrAttr),
    .DefaultAttr(DefAttr), .RstBase(RB), .RstLen(RL), .RstAttr(RA)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .cfg_we_i(cfgWe), .cfg_idx_i(cfgIdx), .cfg_base_i(cfgBase),
    .cfg_len_i(cfgLen), .cfg_attr_i(cfgAttr), .cfg_lock_i(cfgLock),
    .cfg_err_o(cfgErr),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
    .rsp_hit_o(rspHit), .rsp_idx_o(rspIdx), .rsp_attr_o(rspAttr),
    .rsp_multihit_o(rspMulti)
  );

  typedef struct packed {
    logic              hit;
    logic [IdxW-1:0]   idx;
    logic [NrAttr-1:0] attr;
    logic              multi;
  } res_t;

  // Reference model: region table plus the two result slots of the pipe.
  logic [AddrWidth-1:0] mBase [NrRules];
  logic [AddrWidth-1:0] mLen  [NrRules];
  logic [NrAttr-1:0]    mAttr [NrRules];
  logic                 mLock [8];
  logic                 mErr, mS0V, mS1V, mLastAccept;
  res_t                 mS0R, mS1R;

  int nChecks = 0;
  int nFails  = 0;
  int dutConsumed = 0;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    logic [NrRules-1:0][AddrWidth-1:0] rb, rl;
    logic [NrRules-1:0][NrAttr-1:0]    ra;
    rb = RB; rl = RL; ra = RA;
    for (int k = 0; k < NrRules; k++) begin
      mBase[k] = rb[k]; mLen[k] = rl[k]; mAttr[k] = ra[k];
    end
    for (int k = 0; k < 8; k++) mLock[k] = 1'b0;
    mErr = 1'b0; mS0V = 1'b0; mS1V = 1'b0; mLastAccept = 1'b0;
    mS0R = '0; mS1R = '0;
  endtask

  // Region k covers addresses whose offset from base is below len.
  function automatic res_t refLookup(input logic [63:0] a);
    res_t r;
    int cnt = 0;
    r.hit = 1'b0; r.idx = '0; r.attr = DefAttr; r.multi = 1'b0;
    for (int k = 0; k < NrRules; k++) begin
      if (a >= mBase[k] && (a - mBase[k]) < mLen[k]) begin
        cnt++;
        if (!r.hit) begin
          r.hit = 1'b1; r.idx = IdxW'(k); r.attr = mAttr[k];
        end
      end
    end
`ifdef PMA_MULTIHIT_ERR_EN
    r.multi = (cnt > 1);
`endif
    return r;
  endfunction

  task automatic resetCheck(input string tag);
    checkEq({tag, "_rsp_valid"}, rspValid, 0);
    checkEq({tag, "_hit"},       rspHit,   0);
    checkEq({tag, "_idx"},       rspIdx,   0);
    checkEq({tag, "_attr"},      rspAttr,  DefAttr);
    checkEq({tag, "_multi"},     rspMulti, 0);
    checkEq({tag, "_cfg_err"},   cfgErr,   0);
    checkEq({tag, "_req_ready"}, reqReady, 1);
  endtask

  // Check outputs mid-cycle, then advance the model across the next edge.
  task automatic cycle();
    logic rdy, bad;
    @(negedge clk);
    rdy = (!mS0V || !mS1V || rspReady) && !flush;
    checkEq("req_ready", reqReady, rdy);
    checkEq("rsp_valid", rspValid, mS1V);
    if (mS1V) begin
      checkEq("rsp_hit",   rspHit,   mS1R.hit);
      checkEq("rsp_idx",   rspIdx,   mS1R.idx);
      checkEq("rsp_attr",  rspAttr,  mS1R.attr);
      checkEq("rsp_multi", rspMulti, mS1R.multi);
    end
    checkEq("cfg_err", cfgErr, mErr);
    if (rspValid && rspReady) dutConsumed++;

    mLastAccept = rdy && reqValid;
    if (flush) begin
      mS0V = 1'b0; mS1V = 1'b0;
    end else begin
      if (!mS1V || rspReady) begin
        mS1V = mS0V; mS1R = mS0R;
      end
      if (rdy) begin
        mS0V = reqValid;
        if (reqValid) mS0R = refLookup(reqAddr);
      end
    end
    bad  = (int'(cfgIdx) >= NrRules) ? 1'b1 : mLock[cfgIdx];
    mErr = cfgWe && bad;
    if (cfgWe && !bad) begin
      mBase[cfgIdx] = cfgBase; mLen[cfgIdx] = cfgLen;
      mAttr[cfgIdx] = cfgAttr; mLock[cfgIdx] = cfgLock;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush = 0; cfgWe = 0; cfgLock = 0; reqValid = 0; rspReady = 1;
    cfgIdx = '0; cfgBase = '0; cfgLen = '0; cfgAttr = '0; reqAddr = '0;
  endtask

  task automatic writeEntry(input logic [IdxW-1:0] idx, input logic [63:0] base,
                            input logic [63:0] len, input logic [NrAttr-1:0] attr,
                            input logic lock);
    cfgWe = 1; cfgIdx = idx; cfgBase = base; cfgLen = len; cfgAttr = attr; cfgLock = lock;
    cycle();
    cfgWe = 0; cfgLock = 0;
  endtask

  task automatic lookup(input logic [63:0] a);
    reqValid = 1; reqAddr = a;
    cycle();
    reqValid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [63:0] s5Addr [4];
    int s5Next;
    rst = 1;
    idleInputs();
    #12;
    resetCheck("reset");
    @(posedge clk);
    #1 rst = 0;
    resetModel();

    // 1: basic hit / just-past-end miss, plus reset-programmed entry 4
    writeEntry(0, 64'h8000_0000, 64'h1000, 3'b110, 0);
    lookup(64'h8000_0FFF);
    lookup(64'h8000_1000);
    lookup(64'h4010);
    idle(3);

    // 2: overlap resolves to the lowest index
    writeEntry(0, 64'h1000, 64'h1000, 3'b100, 0);
    writeEntry(2, 64'h1800, 64'h100, 3'b001, 0);
    lookup(64'h1880);
    lookup(64'h1900);
    lookup(64'h1800);
    idle(3);

    // 3: region ending at the top of the space; zero-length entry
    writeEntry(1, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b010, 0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF);
    lookup(64'hFFFF_FFFF_FFFF_EFFF);
    writeEntry(2, 64'h0, 64'h0, 3'b111, 0);
    lookup(64'h0);
    lookup(64'h1800);
    idle(3);

    // 4: lock and out-of-range writes are refused
    writeEntry(3, 64'h3000, 64'h10, 3'b011, 1);
    writeEntry(3, 64'h5000, 64'h10, 3'b100, 0);
    idle(1);
    lookup(64'h3004);
    lookup(64'h5004);
    writeEntry(5, 64'h6000, 64'h10, 3'b111, 0);
    writeEntry(7, 64'h6000, 64'h10, 3'b111, 0);
    idle(3);

    // 5: four back-to-back requests against a stalled consumer
    s5Addr[0] = 64'h1010; s5Addr[1] = 64'h3008; s5Addr[2] = 64'h9999; s5Addr[3] = 64'hFFFF_FFFF_FFFF_F800;
    dutConsumed = 0;
    s5Next = 0;
    rspReady = 0;
    reqValid = 1;
    for (int c = 0; c < 16; c++) begin
      rspReady = (c >= 3);
      reqAddr  = s5Addr[s5Next];
      cycle();
      if (mLastAccept) s5Next++;
      if (s5Next == 4) break;
    end
    reqValid = 0; rspReady = 1;
    idle(4);
    checkEq("s5_responses", dutConsumed, 4);

    // 6a: write and lookup in the same cycle sees the old entry
    cfgWe = 1; cfgIdx = 0; cfgBase = 64'h1000; cfgLen = 64'h1000; cfgAttr = 3'b111;
    reqValid = 1; reqAddr = 64'h1100;
    cycle();
    cfgWe = 0; reqValid = 0;
    lookup(64'h1100);
    idle(3);

    // 6b: flush with two lookups in flight; request during flush refused
    reqValid = 1; reqAddr = 64'h1200; cycle();
    reqAddr = 64'h1300; cycle();
    flush = 1; reqAddr = 64'h1400; cycle();
    flush = 0; reqValid = 0;
    idle(3);

    // 6c: asynchronous reset in the middle of a stream
    reqValid = 1;
    for (int i = 0; i < 3; i++) begin
      reqAddr = 64'h1000 + 64'(i * 16);
      cycle();
    end
    #2 rst = 1;
    #1 resetCheck("mid_reset");
    resetModel();
    idleInputs();
    #3 rst = 0;
    @(posedge clk);
    #1;
    lookup(64'h3004);
    lookup(64'h4000);
    idle(3);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      cfgWe    = ($urandom_range(0, 7) == 0);
      cfgIdx   = IdxW'($urandom_range(0, 7));
      cfgBase  = 64'($urandom_range(0, 15)) * 64'h1000;
      cfgLen   = ($urandom_range(0, 3) == 0) ? 64'h0 : 64'($urandom_range(1, 16'h3000));
      cfgAttr  = NrAttr'($urandom_range(0, 7));
      cfgLock  = ($urandom_range(0, 31) == 0);
      reqValid = ($urandom_range(0, 9) < 7);
      reqAddr  = ($urandom_range(0, 19) == 0) ? ~64'($urandom_range(0, 16'hFFFF))
                                                : 64'($urandom_range(0, 32'h13000));
      rspReady = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 31) == 0);
      if (c == 750) begin
        writeEntry(1, 64'hFFFF_FFFF_FFFF_0000, 64'h10000, 3'b010, 0);
      end
      cycle();
    end
    idleInputs();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
